// File: rtl/sprite_scheduler.sv
// sprite_scheduler: per-pixel sprite hit-test, shared RAM address issue, latency-aligned colour-key compositing and PLAY/LOSE mode FSM.
// Optional macro SPRITE_SCHED_BLINK_EN: the lose banner blinks 32 frames on / 32 frames off.
module sprite_scheduler #(
    parameter int              NUM_SPRITES = 4,
    parameter int              SPRITE_W    = 50,
    parameter int              SPRITE_H    = 50,
    parameter int              ADDR_W      = 13,
    parameter int              COLOR_W     = 12,
    parameter int              RAM_LAT     = 2,
    parameter logic [11:0]     KEY_COLOR   = 12'hF0F
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [9:0]               x,
    input  logic [8:0]               y,
    input  logic [10*NUM_SPRITES-1:0] sprite_x,
    input  logic [9*NUM_SPRITES-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]   sprite_en,
    input  logic [COLOR_W-1:0]       bg_color,
    input  logic                     lose,
    input  logic                     restart,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic [1:0]               rom_sel,
    input  logic [COLOR_W-1:0]       rom_color,
    output logic [COLOR_W-1:0]       pixel_out,
    output logic                     pixel_valid,
    output logic                     mode
);
    typedef enum logic {PLAY = 1'b0, LOSE = 1'b1} state_t;
    state_t state_q, state_d;
    logic lose_pend_q, lose_pend_d, restart_pend_q, restart_pend_d;
    logic frame_start, commit, banner_ok, hit_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [1:0] rom_sel_q, rom_sel_d;
    logic [RAM_LAT:0] hit_q, vld_q;
    logic [COLOR_W-1:0] bg_q [0:RAM_LAT];
    logic [COLOR_W-1:0] pixel_out_q;
    logic pixel_valid_q;

    assign frame_start = in_valid && x == '0 && y == '0;
    assign rom_addr    = rom_addr_q;
    assign rom_sel     = rom_sel_q;
    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;
    assign mode        = state_q;

`ifdef SPRITE_SCHED_BLINK_EN
    logic [5:0] blink_q, blink_d;
    // Frame counter: restarts on entering LOSE, advances each frame start while in LOSE.
    always_comb begin
        blink_d = (state_q == PLAY && state_d == LOSE) ? 6'd0 :
                  (state_q == LOSE && frame_start) ? blink_q + 6'd1 : blink_q;
    end
    // Counter register.
    always_ff @(posedge clk) begin
        if (!resetn) blink_q <= '0;
        else         blink_q <= blink_d;
    end
    assign banner_ok = !blink_d[5];
`else
    assign banner_ok = 1'b1;
`endif

    // Mode FSM: requests are latched as pending and only committed at a frame start.
    always_comb begin
        state_d        = state_q;
        lose_pend_d    = 1'b0;
        restart_pend_d = 1'b0;
        commit         = frame_start && (state_q == PLAY ? lose_pend_q : restart_pend_q);
        if (commit)
            state_d = (state_q == PLAY) ? LOSE : PLAY;
        else if (state_q == PLAY)
            lose_pend_d = !restart && (lose || lose_pend_q);
        else
            restart_pend_d = restart || restart_pend_q;
    end

    // Hit test against every box using the post-commit mode; lowest eligible index wins, address holds on miss.
    always_comb begin
        hit_d      = 1'b0;
        rom_addr_d = rom_addr_q;
        rom_sel_d  = rom_sel_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (in_valid && sprite_en[i] &&
                ((i == NUM_SPRITES - 1) ? (state_d == LOSE && banner_ok) : (state_d == PLAY)) &&
                x >= sprite_x[10*i +: 10] &&
                {1'b0, x} < {1'b0, sprite_x[10*i +: 10]} + 11'(SPRITE_W) &&
                y >= sprite_y[9*i +: 9] &&
                {1'b0, y} < {1'b0, sprite_y[9*i +: 9]} + 10'(SPRITE_H)) begin
                hit_d      = 1'b1;
                rom_sel_d  = 2'(i);
                rom_addr_d = ADDR_W'(32'(x - sprite_x[10*i +: 10]) + SPRITE_W * 32'(y - sprite_y[9*i +: 9]));
            end
        end
    end

    // State, address stage and sideband delay line matching the RAM latency, then the composite register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= PLAY;
            lose_pend_q    <= 1'b0;
            restart_pend_q <= 1'b0;
            rom_addr_q     <= '0;
            rom_sel_q      <= '0;
            hit_q          <= '0;
            vld_q          <= '0;
            for (int i = 0; i <= RAM_LAT; i++) bg_q[i] <= '0;
            pixel_out_q    <= '0;
            pixel_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            lose_pend_q    <= lose_pend_d;
            restart_pend_q <= restart_pend_d;
            rom_addr_q     <= rom_addr_d;
            rom_sel_q      <= rom_sel_d;
            hit_q          <= {hit_q[RAM_LAT-1:0], hit_d};
            vld_q          <= {vld_q[RAM_LAT-1:0], in_valid};
            bg_q[0]        <= bg_color;
            for (int i = 1; i <= RAM_LAT; i++) bg_q[i] <= bg_q[i-1];
            pixel_out_q    <= (hit_q[RAM_LAT] && rom_color != KEY_COLOR) ? rom_color : bg_q[RAM_LAT];
            pixel_valid_q  <= vld_q[RAM_LAT];
        end
    end
endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Per-pixel scheduler that shares one sprite image/palette RAM chain among NUM_SPRITES requesters (fruit sprites plus the lose banner).
- Each cycle: hit-tests the current VGA coordinate against all sprite boxes, picks a winner by fixed priority and issues the RAM address.
- Aligns the sideband data with the RAM read latency, then composites the returned colour over the background with colour-key transparency.
- Owns the PLAY/LOSE screen-mode FSM, which switches only on frame boundaries. Sits between the VGA timing generator and the VGA output register.

Parameters:
- NUM_SPRITES, 4, number of requesters; index NUM_SPRITES-1 is the lose banner.
- SPRITE_W, 50, sprite width in pixels.
- SPRITE_H, 50, sprite height in pixels.
- ADDR_W, 13, image RAM address width (clog2(SPRITE_W*SPRITE_H)+1).
- COLOR_W, 12, bits per colour.
- RAM_LAT, 2, cycles from rom_addr change to matching rom_color (image RAM + palette RAM).
- KEY_COLOR, 12'hF0F, transparent colour key.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  x/y is an active display pixel.
- x  in  10  pixel column 0..639.
- y  in  9  pixel row 0..479.
- sprite_x  in  10*NUM_SPRITES  packed top-left columns, sprite i at [10*i+9:10*i].
- sprite_y  in  9*NUM_SPRITES  packed top-left rows.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- bg_color  in  COLOR_W  background colour for the current pixel.
- lose  in  1  request switch to LOSE mode (level or pulse).
- restart  in  1  request switch to PLAY mode.
- rom_addr  out  ADDR_W  shared image RAM address.
- rom_sel  out  2  winning sprite index (selects MEMFILE bank).
- rom_color  in  COLOR_W  palette output, RAM_LAT cycles after rom_addr.
- pixel_out  out  COLOR_W  composited colour.
- pixel_valid  out  1  pixel_out corresponds to an in_valid pixel.
- mode  out  1  0=PLAY, 1=LOSE.

Behaviour:
- Reset (resetn=0 at edge): rom_addr=0, rom_sel=0, pixel_out=0, pixel_valid=0, mode=PLAY, pending flags=0, delay lines cleared.
- Hit test for sprite i: x>=sx_i && x<sx_i+SPRITE_W && y>=sy_i && y<sy_i+SPRITE_H.
  - Sums computed in 11/10-bit so boxes near the right/bottom edge do not wrap.
  - A hit also requires sprite_en[i] and in_valid.
- Mode masking:
  - PLAY: sprite NUM_SPRITES-1 is masked.
  - LOSE: only sprite NUM_SPRITES-1 is eligible.
- Priority: lowest eligible index with a hit wins.
- Address: (x-sx)+SPRITE_W*(y-sy), truncated to ADDR_W.
- No hit: rom_addr and rom_sel hold their previous values; hit_d=0.
- Timing:
  - Edge k samples x/y and registers rom_addr, rom_sel, hit, bg_color and in_valid into stage 0.
  - hit/bg/valid pass through a RAM_LAT-deep delay line.
  - Edge k+RAM_LAT+1 registers pixel_out = (hit_d && rom_color!=KEY_COLOR) ? rom_color : bg_d, and pixel_valid = valid_d.
  - Total latency: RAM_LAT+1 edges after sampling; throughput is one pixel per clock, no stalls.
- FSM, PLAY<->LOSE:
  - lose=1 in PLAY sets lose_pending; restart=1 in LOSE sets restart_pending.
  - If lose and restart are asserted in the same cycle, restart wins and lose_pending is cleared.
  - A pending switch commits on the cycle where in_valid && x==0 && y==0; mode updates at that edge and applies from that pixel's hit test onward.
  - Never switches mid-frame.
  - Requests made in the frame-start cycle itself are committed at the next frame start.
- resetn low mid-frame: all state is cleared immediately; the first pixel_valid reappears RAM_LAT+1 edges after in_valid resumes.

Optional Feature:
- Macro SPRITE_SCHED_BLINK_EN.
- Defined:
  - 6-bit frame counter, cleared on entry to LOSE, increments at each frame start while in LOSE.
  - Banner is eligible only while counter[5]==0: 32 frames on, 32 off, repeating.
- Undefined: no counter; banner is always eligible in LOSE.

Test Plan:
- Reset then in_valid stream: pixel_out=0 and pixel_valid=0 until RAM_LAT+1 edges after the first in_valid, then pixel_valid=1.
- Sprite0 at (100,100), sprite1 at (120,110), both enabled, PLAY mode. Pixel (130,115) -> rom_sel=0, rom_addr=30+50*15=780; rom_color=12'h0A0 -> pixel_out=12'h0A0 three edges later (RAM_LAT=2).
- Same pixel with rom_color=12'hF0F and bg_color=12'h123 -> pixel_out=12'h123. Pixel (99,100) -> no hit, pixel_out=bg.
- Sprite2 at (600,440), pixel (639,479) -> hit, addr=39+50*39=1989. Sprite2 at (630,470), pixel (5,5) -> no wrap hit.
- lose pulse at mid-frame (x=300, y=200): mode stays 0 until the next x=0,y=0 in_valid edge, then mode=1, sprites 0..2 are ignored and the banner is drawn. lose and restart in the same cycle while in LOSE -> mode returns to 0 at the next frame start.
- With SPRITE_SCHED_BLINK_EN: in LOSE, the banner is drawn on frames 0-31, absent on 32-63 and drawn again on frame 64.
